reg_file_pair: RTL and testbench
================================

# reg_file_pair

Parametrised general-purpose register file for the tinySoC CPU core: the next generation of the 16×8 file, with a configurable register count and data width. Registers group into even/odd pairs that act as 2·DATA_W-bit pointers, and the block supports in-place increment, decrement and signed-offset add on any pair. It also has a synchronous reset, registered wrap/conflict status flags and optional write-to-read bypass. It sits between the decoder/ALU write-back path and the load/store address generator.

## Interface
- DATA_W, 8, register width in bits
- NUM_REGS, 16, number of registers; even, power of two, ≥4
- BYPASS, 0, 1 = read ports forward wr_data when reading the register being written this cycle
- AW (local), $clog2(NUM_REGS), register select width
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe
- wr_sel  input  AW  register written
- wr_data  input  DATA_W  write data
- a_sel  input  AW  read port A select
- b_sel  input  AW  read port B select
- ptr_sel  input  AW-1  pair index p; pair = {r[2p+1], r[2p]}, odd register is the high byte
- ptr_op  input  2  00 none, 01 inc, 10 dec, 11 add sign-extended ptr_off
- ptr_off  input  DATA_W  signed offset for ptr_op=11
- out_a  output  DATA_W  r[a_sel]
- out_b  output  DATA_W  r[b_sel]
- out_ptr  output  2·DATA_W  current pair value {r[2p+1], r[2p]}
- ptr_wrap  output  1  registered; 1 for one cycle after a pair op crossed 0/2^(2·DATA_W)
- ptr_conflict  output  1  registered; 1 for one cycle after a pair op was suppressed by a write

## Operation
- Reset: all registers = 0, ptr_wrap = 0, ptr_conflict = 0. out_a, out_b and out_ptr then read 0. rst overrides wr_en and ptr_op in the same cycle.
- Write: wr_en=1 sets r[wr_sel] <= wr_data at the edge.
- Pair op (ptr_op≠00): pair P <= P + delta, modulo 2^(2·DATA_W).
  - inc: delta = +1
  - dec: delta = −1
  - add: delta = ptr_off sign-extended to 2·DATA_W bits
- Wrap is detected from the unsigned carry/borrow out of the 2·DATA_W-bit sum:
  - inc of all-ones → 0, wrap=1
  - dec of 0 → all-ones, wrap=1
  - add with positive offset and carry out → wrap=1
  - add with negative offset and no carry out → wrap=1
  - otherwise wrap=0.
- Conflict: if wr_en=1 and wr_sel>>1 == ptr_sel, the write completes and the whole pair op is suppressed. Neither byte takes the pair result. ptr_conflict=1 next cycle and ptr_wrap=0.
- A write to a different pair proceeds in parallel with the pair op.
- ptr_op=00 clears both flags on the next edge.
- Reads: out_a, out_b and out_ptr are combinational from current state. Pair-op results are never forwarded.
- BYPASS=1: if wr_en and a_sel==wr_sel, out_a = wr_data; same rule for out_b. out_ptr forwards the written byte when its pair is being written.
- BYPASS=0: reads return the pre-edge value.

## Timing
- Write and pair-op latency is 1 cycle; the new value is visible on reads the cycle after the edge.
- Flags are valid the cycle after the op and are held for exactly one cycle unless another op re-asserts them.
- Back-to-back pair ops on the same pair every cycle are supported; each uses the updated value.
- Reset mid-sequence: the op issued in the reset cycle is discarded and the flags clear.
- No handshake: one op per cycle, always accepted.

## Structure
- Shared package tinysoc_pkg holds the ptr_op encodings (PTR_NONE, PTR_INC, PTR_DEC, PTR_ADD).
- The DATA_W default is also shared with the core in tinysoc_pkg.
- One sub-module, pair_adder: a 2·DATA_W-bit adder taking value, op and offset, returning sum and wrap. Combinational; reused by the address generator.
- The register array and flags live in reg_file_pair itself.

## Test plan
- Reset then read all registers → all 0, ptr_wrap=0, ptr_conflict=0. Write r5=0xA7, read on A and B next cycle → 0xA7.
- Pair 1 = 0x00FF, inc → r3=0x01, r2=0x00, ptr_wrap=0. Pair 1 = 0xFFFF, inc → 0x0000, ptr_wrap=1 for exactly one cycle.
- Pair 2 = 0x0000, dec → 0xFFFF, ptr_wrap=1. Pair 2 = 0x1000, add ptr_off=0x80 (−128) → 0x0F80, ptr_wrap=0.
- Same cycle: write r6=0x55 and pair op inc on pair 3 (0x1234) → r6=0x55, r7=0x12, ptr_conflict=1, pair not incremented. Write r0 with inc on pair 3 in parallel → both take effect.
- BYPASS=1: write r4=0x3C with a_sel=4 → out_a=0x3C in the same cycle. BYPASS=0 → out_a shows the old value that cycle.
- Assert rst in the same cycle as inc on 0xFFFF → pair reads 0 and ptr_wrap=0 the next cycle.

Source files
------------

// File: rtl/tinysoc_pkg.sv
// tinysoc_pkg: shared tinySoC definitions.
//   ptr_op_e   - pair-op encodings (PTR_NONE, PTR_INC, PTR_DEC, PTR_ADD)
//   DATA_W_DEF - default core data width
package tinysoc_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        PTR_NONE = 2'b00,
        PTR_INC  = 2'b01,
        PTR_DEC  = 2'b10,
        PTR_ADD  = 2'b11
    } ptr_op_e;

endpackage

// File: rtl/pair_adder.sv
// pair_adder: combinational 2*DATA_W-bit pointer adder with wrap detection.
//   value - current pair value
//   op    - ptr_op encoding (none/inc/dec/add)
//   off   - signed offset used by PTR_ADD, sign-extended to 2*DATA_W bits
//   sum   - value + delta modulo 2^(2*DATA_W)
//   wrap  - the sum crossed 0 / 2^(2*DATA_W)
module pair_adder
    import tinysoc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2*DATA_W-1:0] value,
    input  logic [1:0]          op,
    input  logic [DATA_W-1:0]   off,
    output logic [2*DATA_W-1:0] sum,
    output logic                wrap
);

    logic [2*DATA_W-1:0] delta;
    logic                carry;
    logic                neg;

    always_comb begin
        delta = (op == PTR_INC) ? {{(2*DATA_W-1){1'b0}}, 1'b1} :
                (op == PTR_DEC) ? {(2*DATA_W){1'b1}} :
                (op == PTR_ADD) ? {{DATA_W{off[DATA_W-1]}}, off} :
                                  {(2*DATA_W){1'b0}};
        {carry, sum} = {1'b0, value} + {1'b0, delta};
        // A negative delta wraps exactly when the unsigned add produces no carry.
        neg = (op == PTR_DEC) || ((op == PTR_ADD) && off[DATA_W-1]);
        wrap = (op != PTR_NONE) && (carry ^ neg);
    end

endmodule

// File: rtl/reg_file_pair.sv
// reg_file_pair: NUM_REGS x DATA_W register file with even/odd pointer pairs.
//   clk, rst          - clock, synchronous active-high reset
//   wr_en/sel/data    - single write port
//   a_sel, b_sel      - read port selects, out_a/out_b results
//   ptr_sel           - pair index p, pair = {r[2p+1], r[2p]}
//   ptr_op, ptr_off   - in-place inc/dec/add on the selected pair
//   out_ptr           - current pair value
//   ptr_wrap          - registered: last pair op wrapped
//   ptr_conflict      - registered: last pair op was suppressed by a write to its pair
module reg_file_pair
    import tinysoc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 16,
    parameter int BYPASS   = 0,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_sel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [AW-1:0]       a_sel,
    input  logic [AW-1:0]       b_sel,
    input  logic [AW-2:0]       ptr_sel,
    input  logic [1:0]          ptr_op,
    input  logic [DATA_W-1:0]   ptr_off,
    output logic [DATA_W-1:0]   out_a,
    output logic [DATA_W-1:0]   out_b,
    output logic [2*DATA_W-1:0] out_ptr,
    output logic                ptr_wrap,
    output logic                ptr_conflict
);

    logic [DATA_W-1:0]   r [NUM_REGS];
    logic [AW-1:0]       lo_idx;
    logic [AW-1:0]       hi_idx;
    logic [2*DATA_W-1:0] sum;
    logic                wrap;
    logic                op_act;
    logic                conflict;
    logic                upd;
    logic                byp;

    assign lo_idx   = {ptr_sel, 1'b0};
    assign hi_idx   = {ptr_sel, 1'b1};
    assign op_act   = ptr_op != PTR_NONE;
    // A write into the selected pair wins; the pair op is dropped entirely.
    assign conflict = wr_en && (wr_sel[AW-1:1] == ptr_sel);
    assign upd      = op_act && !conflict;
    assign byp      = (BYPASS != 0) && wr_en;

    pair_adder #(.DATA_W(DATA_W)) u_add (
        .value (out_ptr_raw()),
        .op    (ptr_op),
        .off   (ptr_off),
        .sum   (sum),
        .wrap  (wrap)
    );

    function automatic logic [2*DATA_W-1:0] out_ptr_raw();
        return {r[hi_idx], r[lo_idx]};
    endfunction

    always_comb begin
        out_a   = (byp && a_sel == wr_sel) ? wr_data : r[a_sel];
        out_b   = (byp && b_sel == wr_sel) ? wr_data : r[b_sel];
        out_ptr = {(byp && hi_idx == wr_sel) ? wr_data : r[hi_idx],
                   (byp && lo_idx == wr_sel) ? wr_data : r[lo_idx]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
            ptr_wrap     <= 1'b0;
            ptr_conflict <= 1'b0;
        end else begin
            if (upd) begin
                r[lo_idx] <= sum[DATA_W-1:0];
                r[hi_idx] <= sum[2*DATA_W-1:DATA_W];
            end
            if (wr_en) r[wr_sel] <= wr_data;
            ptr_wrap     <= upd && wrap;
            ptr_conflict <= op_act && conflict;
        end
    end

endmodule

// File: tb/tb_reg_file_pair.sv
// tb_reg_file_pair: checks BYPASS=0 and BYPASS=1 instances against a pair-arithmetic model.
module tb_reg_file_pair;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_sel = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] a_sel = '0;
    logic [3:0] b_sel = '0;
    logic [2:0] ptr_sel = '0;
    logic [1:0] ptr_op = '0;
    logic [7:0] ptr_off = '0;

    logic [7:0]  o0_a, o0_b, o1_a, o1_b;
    logic [15:0] o0_ptr, o1_ptr;
    logic        o0_wrap, o0_conf, o1_wrap, o1_conf;

    int checks = 0;
    int errors = 0;

    logic [7:0] m [16];
    logic       m_wrap = 1'b0;
    logic       m_conf = 1'b0;

    always #5 clk = ~clk;

    reg_file_pair #(.DATA_W(8), .NUM_REGS(16), .BYPASS(0)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .a_sel(a_sel), .b_sel(b_sel), .ptr_sel(ptr_sel), .ptr_op(ptr_op), .ptr_off(ptr_off),
        .out_a(o0_a), .out_b(o0_b), .out_ptr(o0_ptr), .ptr_wrap(o0_wrap), .ptr_conflict(o0_conf)
    );

    reg_file_pair #(.DATA_W(8), .NUM_REGS(16), .BYPASS(1)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .a_sel(a_sel), .b_sel(b_sel), .ptr_sel(ptr_sel), .ptr_op(ptr_op), .ptr_off(ptr_off),
        .out_a(o1_a), .out_b(o1_b), .out_ptr(o1_ptr), .ptr_wrap(o1_wrap), .ptr_conflict(o1_conf)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fwd(input int sel);
        return (wr_en && int'(wr_sel) == sel) ? wr_data : m[sel];
    endfunction

    task automatic model_edge();
        int  p, d, np;
        bit  conf;
        if (rst) begin
            for (int i = 0; i < 16; i++) m[i] = 8'h00;
            m_wrap = 0;
            m_conf = 0;
            return;
        end
        conf = wr_en && (int'(wr_sel) / 2 == int'(ptr_sel));
        m_wrap = 0;
        m_conf = (ptr_op != 2'd0) && conf;
        if (ptr_op != 2'd0 && !conf) begin
            p  = int'(m[2*ptr_sel+1]) * 256 + int'(m[2*ptr_sel]);
            d  = (ptr_op == 2'd1) ? 1 : (ptr_op == 2'd2) ? -1 : int'($signed(ptr_off));
            np = p + d;
            m_wrap = (np < 0) || (np > 65535);
            np = np & 16'hFFFF;
            m[2*ptr_sel]   = np[7:0];
            m[2*ptr_sel+1] = np[15:8];
        end
        if (wr_en) m[wr_sel] = wr_data;
    endtask

    task automatic step();
        @(negedge clk);
        chk("nb_a", {8'h0, o0_a}, {8'h0, m[a_sel]});
        chk("nb_b", {8'h0, o0_b}, {8'h0, m[b_sel]});
        chk("nb_ptr", o0_ptr, {m[2*ptr_sel+1], m[2*ptr_sel]});
        chk("nb_wrap", {15'h0, o0_wrap}, {15'h0, m_wrap});
        chk("nb_conf", {15'h0, o0_conf}, {15'h0, m_conf});
        chk("by_a", {8'h0, o1_a}, {8'h0, fwd(int'(a_sel))});
        chk("by_b", {8'h0, o1_b}, {8'h0, fwd(int'(b_sel))});
        chk("by_ptr", o1_ptr, {fwd(2*ptr_sel+1), fwd(2*ptr_sel)});
        chk("by_wrap", {15'h0, o1_wrap}, {15'h0, m_wrap});
        chk("by_conf", {15'h0, o1_conf}, {15'h0, m_conf});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit rs, input bit we, input int ws, input int wd,
                         input int as, input int bs, input int ps, input int op, input int off);
        rst = rs; wr_en = we; wr_sel = 4'(ws); wr_data = 8'(wd);
        a_sel = 4'(as); b_sel = 4'(bs); ptr_sel = 3'(ps); ptr_op = 2'(op); ptr_off = 8'(off);
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m[i] = 8'hxx;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, i, 15 - i, i / 2, 0, 0);
        drive(0, 1, 5, 'hA7, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 5, 5, 0, 0, 0);
        chk("r5_a", {8'h0, o0_a}, 16'h00A7);
        chk("r5_b", {8'h0, o0_b}, 16'h00A7);
        drive(0, 1, 2, 'hFF, 0, 0, 1, 0, 0);
        drive(0, 1, 3, 'h00, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 3, 2, 1, 1, 0);
        chk("p1_inc", o0_ptr, 16'h0100);
        chk("p1_inc_wrap", {15'h0, o0_wrap}, 16'h0);
        drive(0, 1, 2, 'hFF, 0, 0, 1, 0, 0);
        drive(0, 1, 3, 'hFF, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("p1_wrap_val", o0_ptr, 16'h0000);
        chk("p1_wrap_flag", {15'h0, o0_wrap}, 16'h1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("p1_wrap_clr", {15'h0, o0_wrap}, 16'h0);
        drive(0, 1, 4, 'h00, 0, 0, 2, 0, 0);
        drive(0, 1, 5, 'h00, 0, 0, 2, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 2, 2, 0);
        chk("p2_dec", o0_ptr, 16'hFFFF);
        chk("p2_dec_wrap", {15'h0, o0_wrap}, 16'h1);
        drive(0, 1, 5, 'h10, 0, 0, 2, 0, 0);
        drive(0, 1, 4, 'h00, 0, 0, 2, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 2, 3, 'h80);
        chk("p2_add", o0_ptr, 16'h0F80);
        chk("p2_add_wrap", {15'h0, o0_wrap}, 16'h0);
        drive(0, 1, 7, 'h12, 0, 0, 3, 0, 0);
        drive(0, 1, 6, 'h34, 0, 0, 3, 0, 0);
        drive(0, 1, 6, 'h55, 6, 7, 3, 1, 0);
        chk("conf_ptr", o0_ptr, 16'h1255);
        chk("conf_flag", {15'h0, o0_conf}, 16'h1);
        chk("conf_wrap", {15'h0, o0_wrap}, 16'h0);
        drive(0, 1, 0, 'hAA, 0, 0, 3, 1, 0);
        chk("par_ptr", o0_ptr, 16'h1256);
        chk("par_r0", {8'h0, o0_a}, 16'h00AA);
        chk("par_conf", {15'h0, o0_conf}, 16'h0);
        drive(0, 1, 4, 'h3C, 4, 4, 2, 0, 0);
        drive(0, 1, 7, 'hFF, 0, 0, 3, 0, 0);
        drive(0, 1, 6, 'hFF, 0, 0, 3, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 3, 1, 0);
        chk("rst_ptr", o0_ptr, 16'h0000);
        chk("rst_wrap", {15'h0, o0_wrap}, 16'h0);
        for (int n = 0; n < 400; n++) begin
            int ps, ws, wd, k;
            ps = int'($urandom_range(0, 7));
            ws = ($urandom_range(0, 3) == 0) ? 2 * ps + int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
            k  = int'($urandom_range(0, 2));
            wd = (k == 0) ? 'h00 : (k == 1) ? 'hFF : int'($urandom_range(0, 255));
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, ws, wd,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), ps,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
